// File: rtl/bsg_fifos_link_sched_pkg.sv
// bsg_fifos_link_sched_pkg
//   Shared types and helpers for the FIFO link scheduler.
//   Parameter constraints for users of this package:
//     num_slots_p >= 2, words_per_pkt_p >= 1, max_credits_p >= 1.
//   Optional feature macro used by the top: BSG_FIFOS_LINK_SCHED_STALL_CNT_EN.
package bsg_fifos_link_sched_pkg;

  typedef enum logic [0:0] {
    E_IDLE = 1'b0,
    E_SEND = 1'b1
  } state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold the value n itself (0..n).
  function automatic int unsigned width_of(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bsg_fifos_link_sched_rr_pick.sv
// bsg_fifos_link_sched_rr_pick
//   Combinational rotating-priority picker. Searches upward from last_i+1
//   (modulo num_slots_p) and selects the first valid slot.
//   Ports:
//     v_i      per-slot request valid
//     last_i   index of the previously served slot
//     grant_o  one-hot selection (0 when nothing valid)
//     addr_o   index of the selected slot
//     any_v_o  at least one request valid
module bsg_fifos_link_sched_rr_pick
  import bsg_fifos_link_sched_pkg::*;
#(
  parameter int unsigned num_slots_p = 4,
  localparam int unsigned lg_w_lp = safe_clog2(num_slots_p)
) (
  input  logic [num_slots_p-1:0] v_i,
  input  logic [lg_w_lp-1:0]     last_i,
  output logic [num_slots_p-1:0] grant_o,
  output logic [lg_w_lp-1:0]     addr_o,
  output logic                   any_v_o
);

  logic [lg_w_lp:0] w_sum;

  always_comb begin
    grant_o = '0;
    addr_o  = '0;
    any_v_o = 1'b0;
    w_sum   = '0;
    // last_i + off is below 2*num_slots_p, so one conditional subtract wraps it.
    for (int unsigned off = 1; off <= num_slots_p; off++) begin
      w_sum = {1'b0, last_i} + (lg_w_lp+1)'(off);
      if (w_sum >= (lg_w_lp+1)'(num_slots_p))
        w_sum = w_sum - (lg_w_lp+1)'(num_slots_p);
      if (!any_v_o && v_i[w_sum[lg_w_lp-1:0]]) begin
        any_v_o                      = 1'b1;
        addr_o                       = w_sum[lg_w_lp-1:0];
        grant_o[w_sum[lg_w_lp-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_fifos_link_scheduler.sv
// bsg_fifos_link_scheduler
//   Packet-granular round-robin scheduler draining per-slot host TX FIFOs
//   onto one shared link, with one-credit-per-packet flow control.
//   Optional: define BSG_FIFOS_LINK_SCHED_STALL_CNT_EN to count E_SEND cycles
//   without a transfer on stall_cycles_o (otherwise tied to 0).
//   Ports:
//     clk_i, reset_n_i         clock, async active-low reset
//     slot_v_i / slot_data_i   per-slot FIFO head valid / data
//     slot_yumi_o              per-slot dequeue (at most one bit set)
//     link_v_o / link_data_o   link word valid / data (data 0 when not valid)
//     link_slot_id_o           source slot of current word
//     link_ready_i             link accepts word
//     credit_return_i          one-cycle pulse returning one packet credit
//     credits_o                current credit count
//     grant_o                  registered one-hot grant, 0 while idle
//     busy_o                   packet in flight
//     credit_overflow_o        sticky: return arrived with pool full
//     stall_cycles_o           optional stall counter
module bsg_fifos_link_scheduler
  import bsg_fifos_link_sched_pkg::*;
#(
  parameter int unsigned num_slots_p     = 4,
  parameter int unsigned width_p         = 32,
  parameter int unsigned words_per_pkt_p = 4,
  parameter int unsigned max_credits_p   = 16
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [num_slots_p-1:0]               slot_v_i,
  input  logic [num_slots_p-1:0][width_p-1:0]  slot_data_i,
  output logic [num_slots_p-1:0]               slot_yumi_o,
  output logic                                 link_v_o,
  output logic [width_p-1:0]                   link_data_o,
  output logic [safe_clog2(num_slots_p)-1:0]   link_slot_id_o,
  input  logic                                 link_ready_i,
  input  logic                                 credit_return_i,
  output logic [width_of(max_credits_p)-1:0]   credits_o,
  output logic [num_slots_p-1:0]               grant_o,
  output logic                                 busy_o,
  output logic                                 credit_overflow_o,
  output logic [31:0]                          stall_cycles_o
);

  localparam int unsigned lg_slots_lp = safe_clog2(num_slots_p);
  localparam int unsigned cred_w_lp   = width_of(max_credits_p);
  localparam int unsigned cnt_w_lp    = safe_clog2(words_per_pkt_p);

  state_e                 r_state;
  logic [cred_w_lp-1:0]   r_credits;
  logic [lg_slots_lp-1:0] r_last;
  logic [lg_slots_lp-1:0] r_gidx;
  logic [cnt_w_lp-1:0]    r_word_cnt;
  logic [num_slots_p-1:0] r_grant;
  logic                   r_overflow;

  logic [num_slots_p-1:0] w_pick_grant;
  logic [lg_slots_lp-1:0] w_pick_addr;
  logic                   w_any_v;
  logic                   w_busy;
  logic                   w_link_v;
  logic                   w_xfer;
  logic                   w_consume;
  logic                   w_last_word;

  bsg_fifos_link_sched_rr_pick #(
    .num_slots_p(num_slots_p)
  ) u_pick (
    .v_i     (slot_v_i),
    .last_i  (r_last),
    .grant_o (w_pick_grant),
    .addr_o  (w_pick_addr),
    .any_v_o (w_any_v)
  );

  assign w_busy      = (r_state == E_SEND);
  assign w_link_v    = w_busy & slot_v_i[r_gidx];
  assign w_xfer      = w_link_v & link_ready_i;
  assign w_consume   = (r_state == E_IDLE) && (r_credits != '0) && w_any_v;
  assign w_last_word = (r_word_cnt == cnt_w_lp'(words_per_pkt_p - 1));

  assign link_v_o          = w_link_v;
  assign link_data_o       = w_link_v ? slot_data_i[r_gidx] : '0;
  assign link_slot_id_o    = w_busy ? r_gidx : '0;
  assign slot_yumi_o       = w_xfer ? r_grant : '0;
  assign grant_o           = r_grant;
  assign busy_o            = w_busy;
  assign credits_o         = r_credits;
  assign credit_overflow_o = r_overflow;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= E_IDLE;
      r_credits  <= cred_w_lp'(max_credits_p);
      r_last     <= lg_slots_lp'(num_slots_p - 1);
      r_gidx     <= '0;
      r_word_cnt <= '0;
      r_grant    <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        E_IDLE: begin
          if (w_consume) begin
            r_state    <= E_SEND;
            r_grant    <= w_pick_grant;
            r_gidx     <= w_pick_addr;
            r_word_cnt <= '0;
          end
        end
        E_SEND: begin
          if (w_xfer) begin
            if (w_last_word) begin
              r_state <= E_IDLE;
              r_last  <= r_gidx;
              r_grant <= '0;
            end else begin
              r_word_cnt <= r_word_cnt + cnt_w_lp'(1);
            end
          end
        end
        default: r_state <= E_IDLE;
      endcase

      // A consume and a return together cancel out.
      if (credit_return_i && !w_consume) begin
        if (r_credits == cred_w_lp'(max_credits_p))
          r_overflow <= 1'b1;
        else
          r_credits <= r_credits + cred_w_lp'(1);
      end else if (w_consume && !credit_return_i) begin
        r_credits <= r_credits - cred_w_lp'(1);
      end
    end
  end

`ifdef BSG_FIFOS_LINK_SCHED_STALL_CNT_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      r_stall <= '0;
    else if (w_busy && !w_xfer && (r_stall != '1))
      r_stall <= r_stall + 32'd1;
  end

  assign stall_cycles_o = r_stall;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_bsg_fifos_link_scheduler.sv
module tb_bsg_fifos_link_scheduler;

  logic             clk;
  logic             reset_n;
  logic [3:0]       slot_v;
  logic [3:0][31:0] slot_data;
  logic [3:0]       slot_yumi;
  logic             link_v;
  logic [31:0]      link_data;
  logic [1:0]       link_id;
  logic             link_ready;
  logic             credit_ret;
  logic [4:0]       credits;
  logic [3:0]       grant;
  logic             busy;
  logic             ovf;
  logic [31:0]      stall;

  bsg_fifos_link_scheduler #(
    .num_slots_p     (4),
    .width_p         (32),
    .words_per_pkt_p (4),
    .max_credits_p   (16)
  ) dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .slot_v_i          (slot_v),
    .slot_data_i       (slot_data),
    .slot_yumi_o       (slot_yumi),
    .link_v_o          (link_v),
    .link_data_o       (link_data),
    .link_slot_id_o    (link_id),
    .link_ready_i      (link_ready),
    .credit_return_i   (credit_ret),
    .credits_o         (credits),
    .grant_o           (grant),
    .busy_o            (busy),
    .credit_overflow_o (ovf),
    .stall_cycles_o    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Bench FIFO model: slot s presents s*0x100 + 0x10 + head[s].
  int unsigned head [4];

  logic [3:0]  c_grant, c_yumi;
  logic        c_v, c_busy, c_ovf;
  logic [31:0] c_data, c_stall;
  logic [1:0]  c_id;
  logic [4:0]  c_cred;

  typedef struct {
    logic [3:0]  v;
    logic        rdy;
    logic        rt;
    logic [3:0]  g;
    logic        lv;
    logic [31:0] d;
    logic [1:0]  id;
    logic [3:0]  y;
    logic [4:0]  cr;
    logic        bz;
    logic        ov;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; applies inputs, samples outputs at negedge, then
  // advances the FIFO heads for any dequeue seen this cycle.
  task automatic cyc(input logic [3:0] v, input logic rdy, input logic rt);
    slot_v     = v;
    link_ready = rdy;
    credit_ret = rt;
    for (int s = 0; s < 4; s++) slot_data[s] = 32'(s) * 32'h100 + 32'h10 + head[s];
    @(negedge clk);
    c_grant = grant; c_yumi = slot_yumi; c_v = link_v; c_busy = busy;
    c_ovf = ovf; c_data = link_data; c_stall = stall; c_id = link_id; c_cred = credits;
    @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) if (c_yumi[s]) head[s]++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    slot_v = '0; link_ready = 1'b0; credit_ret = 1'b0;
    for (int s = 0; s < 4; s++) head[s] = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Packet p of a run with all slots valid and the link always ready.
  task automatic rr_pkt(input int p);
    int s;
    s = p % 4;
    cyc(4'b1111, 1'b1, 1'b0);
    chk($sformatf("rr%0d_idle_grant", p), c_grant, 0);
    chk($sformatf("rr%0d_idle_cred", p), c_cred, 16 - p);
    for (int k = 0; k < 4; k++) begin
      cyc(4'b1111, 1'b1, 1'b0);
      chk($sformatf("rr%0d_w%0d_grant", p, k), c_grant, 32'd1 << s);
      chk($sformatf("rr%0d_w%0d_id", p, k), c_id, s);
      chk($sformatf("rr%0d_w%0d_data", p, k), c_data, s * 32'h100 + 32'h10 + (p / 4) * 4 + k);
      chk($sformatf("rr%0d_w%0d_yumi", p, k), c_yumi, 32'd1 << s);
    end
  endtask

  logic [31:0] exp_stall;

  initial begin
    reset_n = 1'b0;
    slot_v = '0; link_ready = 1'b0; credit_ret = 1'b0; slot_data = '0;

    //                v        rdy   rt    g        lv    d           id     y        cr     bz    ov
    vecs[0]  = '{4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,      2'd0, 4'b0000, 5'd16, 1'b0, 1'b0};
    vecs[1]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 32'h210,    2'd2, 4'b0100, 5'd15, 1'b1, 1'b0};
    vecs[2]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 32'h211,    2'd2, 4'b0100, 5'd15, 1'b1, 1'b0};
    vecs[3]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 32'h212,    2'd2, 4'b0100, 5'd15, 1'b1, 1'b0};
    vecs[4]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 32'h213,    2'd2, 4'b0100, 5'd15, 1'b1, 1'b0};
    vecs[5]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,      2'd0, 4'b0000, 5'd15, 1'b0, 1'b0};
    vecs[6]  = '{4'b0001, 1'b1, 1'b1, 4'b0000, 1'b0, 32'h0,      2'd0, 4'b0000, 5'd15, 1'b0, 1'b0};
    vecs[7]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 32'h010,    2'd0, 4'b0001, 5'd15, 1'b1, 1'b0};
    vecs[8]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 32'h011,    2'd0, 4'b0001, 5'd15, 1'b1, 1'b0};
    vecs[9]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 32'h012,    2'd0, 4'b0001, 5'd15, 1'b1, 1'b0};
    vecs[10] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 32'h013,    2'd0, 4'b0001, 5'd15, 1'b1, 1'b0};
    vecs[11] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,      2'd0, 4'b0000, 5'd15, 1'b0, 1'b0};
    vecs[12] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 32'h0,      2'd0, 4'b0000, 5'd15, 1'b0, 1'b0};
    vecs[13] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 32'h0,      2'd0, 4'b0000, 5'd16, 1'b0, 1'b0};
    vecs[14] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,      2'd0, 4'b0000, 5'd16, 1'b0, 1'b1};

`ifdef BSG_FIFOS_LINK_SCHED_STALL_CNT_EN
    exp_stall = 32'd5;
`else
    exp_stall = 32'd0;
`endif

    // Reset state
    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_link_v", link_v, 0);
    chk("rst_yumi", slot_yumi, 0);
    chk("rst_credits", credits, 16);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_stall", stall, 0);

    // Single packet, consume+return, overflow
    for (int i = 0; i < 15; i++) begin
      cyc(vecs[i].v, vecs[i].rdy, vecs[i].rt);
      chk($sformatf("v%0d_grant", i), c_grant, vecs[i].g);
      chk($sformatf("v%0d_link_v", i), c_v, vecs[i].lv);
      chk($sformatf("v%0d_data", i), c_data, vecs[i].d);
      chk($sformatf("v%0d_id", i), c_id, vecs[i].id);
      chk($sformatf("v%0d_yumi", i), c_yumi, vecs[i].y);
      chk($sformatf("v%0d_cred", i), c_cred, vecs[i].cr);
      chk($sformatf("v%0d_busy", i), c_busy, vecs[i].bz);
      chk($sformatf("v%0d_ovf", i), c_ovf, vecs[i].ov);
    end

    // Round-robin fairness then credit exhaustion
    do_reset();
    chk("rst2_ovf", ovf, 0);
    for (int p = 0; p < 16; p++) rr_pkt(p);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b1111, 1'b1, 1'b0);
      chk($sformatf("ex%0d_busy", i), c_busy, 0);
      chk($sformatf("ex%0d_grant", i), c_grant, 0);
      chk($sformatf("ex%0d_cred", i), c_cred, 0);
      chk($sformatf("ex%0d_yumi", i), c_yumi, 0);
    end
    cyc(4'b1111, 1'b1, 1'b1);
    chk("ret_cred0", c_cred, 0);
    chk("ret_busy0", c_busy, 0);
    cyc(4'b1111, 1'b1, 1'b0);
    chk("ret_cred1", c_cred, 1);
    chk("ret_busy1", c_busy, 0);
    cyc(4'b1111, 1'b1, 1'b0);
    chk("ret_grant", c_grant, 4'b0001);
    chk("ret_cred_used", c_cred, 0);
    chk("ret_data", c_data, 32'h020);
    repeat (3) cyc(4'b1111, 1'b1, 1'b0);
    cyc(4'b1111, 1'b1, 1'b0);
    chk("ret_after_busy", c_busy, 0);

    // Backpressure then bubble
    do_reset();
    cyc(4'b0001, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      cyc(4'b0001, 1'b1, 1'b0);
      chk($sformatf("bp_w%0d_data", k), c_data, 32'h010 + k);
      chk($sformatf("bp_w%0d_yumi", k), c_yumi, 4'b0001);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0001, 1'b0, 1'b0);
      chk($sformatf("bp_st%0d_v", i), c_v, 1);
      chk($sformatf("bp_st%0d_yumi", i), c_yumi, 0);
      chk($sformatf("bp_st%0d_grant", i), c_grant, 4'b0001);
      chk($sformatf("bp_st%0d_data", i), c_data, 32'h012);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(4'b1110, 1'b1, 1'b0);
      chk($sformatf("bub%0d_v", i), c_v, 0);
      chk($sformatf("bub%0d_yumi", i), c_yumi, 0);
      chk($sformatf("bub%0d_grant", i), c_grant, 4'b0001);
      chk($sformatf("bub%0d_data", i), c_data, 0);
      chk($sformatf("bub%0d_busy", i), c_busy, 1);
    end
    for (int k = 2; k < 4; k++) begin
      cyc(4'b1111, 1'b1, 1'b0);
      chk($sformatf("bp_w%0d_data", k), c_data, 32'h010 + k);
      chk($sformatf("bp_w%0d_yumi", k), c_yumi, 4'b0001);
    end
    cyc(4'b1110, 1'b1, 1'b0);
    chk("bp_end_busy", c_busy, 0);
    chk("bp_end_grant", c_grant, 0);
    chk("bp_stall", c_stall, exp_stall);
    cyc(4'b1110, 1'b1, 1'b0);
    chk("bp_next_grant", c_grant, 4'b0010);
    chk("bp_next_id", c_id, 1);

    // Reset mid-packet
    do_reset();
    cyc(4'b0100, 1'b1, 1'b0);
    cyc(4'b0100, 1'b1, 1'b0);
    chk("mr_w0", c_data, 32'h210);
    cyc(4'b0100, 1'b1, 1'b0);
    chk("mr_w1", c_data, 32'h211);
    reset_n = 1'b0;
    #1;
    chk("mr_link_v", link_v, 0);
    chk("mr_grant", grant, 0);
    chk("mr_cred", credits, 16);
    chk("mr_yumi", slot_yumi, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int s = 0; s < 4; s++) head[s] = 0;
    cyc(4'b1111, 1'b1, 1'b0);
    chk("mr_idle_grant", c_grant, 0);
    cyc(4'b1111, 1'b1, 1'b0);
    chk("mr_next_grant", c_grant, 4'b0001);
    chk("mr_next_data", c_data, 32'h010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
